mem_arbiter: RTL

Two-requester controller for the single-port byte memory of the core. It arbitrates between instruction fetch (I-port, word reads only) and the load/store unit (D-port, byte/half/word loads and stores using the funct3 convention). It sequences each access through a small FSM and drives the memory's address, write-data, write-enable and write-length inputs. It returns formatted, sign- or zero-extended load data as a registered single-cycle response.

---
 rtl/mem_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/load-store arbiter and access sequencer for a single-port big-endian byte memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention grants; otherwise the D-port always wins.
module mem_arbiter #(
  parameter int MEM_BYTES = 5096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [2:0]  d_req_funct3,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_enable,
  output logic [2:0]  mem_write_length,
  input  logic [31:0] mem_read_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] i_rsp_data_q, i_rsp_data_d, d_rsp_data_q, d_rsp_data_d;
  logic [31:0] ld_data, st_data;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d, own_d_q, own_d_d;
  logic        i_rsp_valid_q, i_rsp_valid_d, d_rsp_valid_q, d_rsp_valid_d;
  logic        gnt_d, accept, access, in_range;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;
  always_comb begin
    gnt_d = d_req_valid & (~i_req_valid | ~last_d_q);
    last_d_d = accept ? d_req_ready : last_d_q;
  end
  always_ff @(posedge clk) last_d_q <= reset ? 1'b0 : last_d_d;
`else
  always_comb gnt_d = d_req_valid;
`endif
  always_comb begin
    access = state_q == ACCESS;
    d_req_ready = ~reset & ~access & gnt_d;
    i_req_ready = ~reset & ~access & i_req_valid & ~gnt_d;
    accept = d_req_ready | i_req_ready;
    in_range = ({1'b0, addr_q} + 33'd3) < 33'(MEM_BYTES);
    ld_data = ~in_range ? 32'd0 :
              f3_q == 3'd0 ? {{24{mem_read_data[31]}}, mem_read_data[31:24]} :
              f3_q == 3'd1 ? {{16{mem_read_data[31]}}, mem_read_data[31:16]} :
              f3_q == 3'd2 ? mem_read_data :
              f3_q == 3'd4 ? {24'd0, mem_read_data[31:24]} :
              f3_q == 3'd5 ? {16'd0, mem_read_data[31:16]} : 32'd0;
    st_data = f3_q[1:0] == 2'd0 ? {wdata_q[7:0], 24'd0} :
              f3_q[1:0] == 2'd1 ? {wdata_q[15:0], 16'd0} :
              f3_q[1:0] == 2'd2 ? wdata_q : 32'd0;
    mem_address = access ? addr_q : 32'd0;
    mem_write_length = access ? {1'b0, f3_q[1:0]} : 3'd0;
    mem_wr_data = (access & we_q) ? st_data : 32'd0;
    mem_wr_enable = access & we_q & in_range & ~f3_q[2] & (f3_q[1:0] != 2'd3) & ~reset;
    state_d = accept ? ACCESS : access ? RESP : IDLE;
    addr_d = d_req_ready ? d_req_addr : i_req_ready ? i_req_addr : addr_q;
    we_d = d_req_ready ? d_req_we : i_req_ready ? 1'b0 : we_q;
    f3_d = d_req_ready ? d_req_funct3 : i_req_ready ? 3'd2 : f3_q;
    wdata_d = d_req_ready ? d_req_wdata : i_req_ready ? 32'd0 : wdata_q;
    own_d_d = accept ? d_req_ready : own_d_q;
    i_rsp_valid_d = access & ~own_d_q;
    d_rsp_valid_d = access & own_d_q;
    i_rsp_data_d = i_rsp_valid_d ? ld_data : i_rsp_data_q;
    d_rsp_data_d = d_rsp_valid_d ? (we_q ? 32'd0 : ld_data) : d_rsp_data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      f3_q <= '0;
      we_q <= 1'b0;
      own_d_q <= 1'b0;
      i_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      i_rsp_data_q <= '0;
      d_rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      f3_q <= f3_d;
      we_q <= we_d;
      own_d_q <= own_d_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      i_rsp_data_q <= i_rsp_data_d;
      d_rsp_data_q <= d_rsp_data_d;
    end
  end
  assign i_rsp_valid = i_rsp_valid_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign i_rsp_data = i_rsp_data_q;
  assign d_rsp_data = d_rsp_data_q;
endmodule
